// File: rtl/ddr3_test_pkg.sv
// rtl/ddr3_test_pkg.sv - shared state encoding, fail codes and pattern function for the DDR3 self-test
package ddr3_test_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WAIT_CAL = 3'd1,
        ST_WRITE    = 3'd2,
        ST_SETTLE   = 3'd3,
        ST_READ     = 3'd4,
        ST_DRAIN    = 3'd5,
        ST_DONE     = 3'd6
    } state_t;

    localparam logic [1:0] FAIL_NONE     = 2'd0;
    localparam logic [1:0] FAIL_MISMATCH = 2'd1;
    localparam logic [1:0] FAIL_TIMEOUT  = 2'd2;
    localparam logic [1:0] FAIL_CALIB    = 2'd3;

    // Test pattern word for a given index and pass; callers truncate to the data width,
    // which gives the modulo-2^DATA_W wrap.
    function automatic logic [31:0] expected(input logic [31:0] idx, input logic [31:0] pass_num);
        return idx + pass_num;
    endfunction

endpackage

// File: rtl/ddr3_test_checker.sv
// rtl/ddr3_test_checker.sv - read-data compare pipeline with error counter and first-error index
//
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   clear          new test accepted: zero err_cnt and first_err_idx
//   flush          pass aborted: drop the compare launched this cycle
//   rd_en, rd_idx  read strobe and its word index within the pass
//   pass_cnt       current pass number (pattern offset)
//   rd_data        read FIFO data, valid the cycle after rd_en
//   mismatch       compare this cycle failed
//   err_cnt        saturating mismatch count
//   first_err_idx  word index of the first mismatch of the test
module ddr3_test_checker
    import ddr3_test_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int IDX_W  = 11,
    parameter int ERR_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              flush,
    input  logic              rd_en,
    input  logic [IDX_W-1:0]  rd_idx,
    input  logic [31:0]       pass_cnt,
    input  logic [DATA_W-1:0] rd_data,
    output logic              mismatch,
    output logic [ERR_W-1:0]  err_cnt,
    output logic [15:0]       first_err_idx
);

    logic              chk_vld;
    logic [IDX_W-1:0]  chk_idx;
    logic [DATA_W-1:0] chk_exp;

    // The expected word is captured alongside the strobe so the compare stage needs no
    // arithmetic and is immune to pass_cnt changing after the last read of a pass.
    assign mismatch = chk_vld & (rd_data != chk_exp);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chk_vld       <= 1'b0;
            chk_idx       <= '0;
            chk_exp       <= '0;
            err_cnt       <= '0;
            first_err_idx <= '0;
        end else begin
            chk_vld <= rd_en & ~flush;
            if (rd_en) begin
                chk_idx <= rd_idx;
                chk_exp <= DATA_W'(expected(32'(rd_idx), pass_cnt));
            end
            if (clear) begin
                err_cnt       <= '0;
                first_err_idx <= '0;
            end else if (mismatch) begin
                if (err_cnt != '1)
                    err_cnt <= err_cnt + 1'b1;
                // err_cnt saturates instead of wrapping, so zero means no error yet this test
                if (err_cnt == '0)
                    first_err_idx <= 16'(chk_idx);
            end
        end
    end

endmodule

// File: rtl/ddr3_selftest_ctrl.sv
// rtl/ddr3_selftest_ctrl.sv - DDR3 write/read-back self-test sequencer over the user FIFOs
//
// Ports:
//   clk, rst_n            clock (FIFO user clock), asynchronous active-low reset
//   calib_done            DDR3 calibration complete
//   start                 1-cycle pulse, accepted only in IDLE/DONE
//   wr_en, wr_data        write FIFO strobe (combinational) and data (registered)
//   wr_full               write FIFO full
//   rd_mem_enable         lets the DDR3 read side fill the read FIFO (READ/DRAIN)
//   rd_valid, rd_en       read FIFO not-empty and read strobe (combinational)
//   rd_data               read FIFO data, valid one cycle after rd_en
//   busy, done, pass      status; pass is valid with done
//   fail_code             0 none, 1 mismatch, 2 read timeout, 3 calibration lost
//   err_cnt               saturating mismatch count
//   first_err_idx         word index of the first mismatch
module ddr3_selftest_ctrl
    import ddr3_test_pkg::*;
#(
    parameter int DATA_W      = 16,
    parameter int TEST_LEN    = 1300,
    parameter int SETTLE_CYC  = 64,
    parameter int TIMEOUT_CYC = 65535,
    parameter int LOOPS       = 1,
    parameter int ERR_W       = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              calib_done,
    input  logic              start,
    output logic              wr_en,
    output logic [DATA_W-1:0] wr_data,
    input  logic              wr_full,
    output logic              rd_mem_enable,
    input  logic              rd_valid,
    output logic              rd_en,
    input  logic [DATA_W-1:0] rd_data,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [1:0]        fail_code,
    output logic [ERR_W-1:0]  err_cnt,
    output logic [15:0]       first_err_idx
);

    localparam int IDX_W = $clog2(TEST_LEN + 1);
    localparam int SET_W = $clog2(SETTLE_CYC + 2);
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

    localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(TEST_LEN - 1);
    localparam logic [IDX_W-1:0] LEN_IDX     = IDX_W'(TEST_LEN);
    localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE_CYC - 1);
    localparam logic [TMO_W-1:0] TMO_LAST    = TMO_W'(TIMEOUT_CYC - 1);

    state_t           state;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] rd_idx;
    logic [31:0]      pass_cnt;
    logic [SET_W-1:0] settle_cnt;
    logic [TMO_W-1:0] tmo_cnt;
    logic [1:0]       fail_next;

    logic mismatch;
    logic start_ok;
    logic calib_lost;
    logic timed_out;
    logic more_passes;

    assign wr_en = (state == ST_WRITE) & ~wr_full;
    assign rd_en = (state == ST_READ) & rd_valid & (rd_idx < LEN_IDX);

    assign start_ok   = start & ((state == ST_IDLE) | (state == ST_DONE));
    assign calib_lost = ~calib_done & ((state == ST_WRITE) | (state == ST_SETTLE) |
                                       (state == ST_READ)  | (state == ST_DRAIN));
    // Fires on the TIMEOUT_CYC-th consecutive empty cycle since the last read.
    assign timed_out  = (state == ST_READ) & ~rd_valid & (tmo_cnt == TMO_LAST);
    // Written as pass_cnt+1 < LOOPS so LOOPS==1 does not become an unsigned compare against 0.
    assign more_passes = (32'(LOOPS) == 32'd0) || ((pass_cnt + 32'd1) < 32'(LOOPS));

    // fail_code keeps the first cause seen in a test; a compare completing in the same
    // cycle as an abort is still a real mismatch and wins.
    always_comb begin
        fail_next = fail_code;
        if (start_ok) begin
            fail_next = FAIL_NONE;
        end else if (fail_code == FAIL_NONE) begin
            if (mismatch)
                fail_next = FAIL_MISMATCH;
            else if (calib_lost)
                fail_next = FAIL_CALIB;
            else if (timed_out)
                fail_next = FAIL_TIMEOUT;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            idx           <= '0;
            rd_idx        <= '0;
            pass_cnt      <= '0;
            settle_cnt    <= '0;
            tmo_cnt       <= '0;
            wr_data       <= '0;
            rd_mem_enable <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            pass          <= 1'b0;
            fail_code     <= FAIL_NONE;
        end else begin
            fail_code <= fail_next;
            if (calib_lost || timed_out) begin
                state         <= ST_DONE;
                busy          <= 1'b0;
                done          <= 1'b1;
                pass          <= 1'b0;
                rd_mem_enable <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE, ST_DONE: begin
                        if (start) begin
                            state    <= ST_WAIT_CAL;
                            busy     <= 1'b1;
                            done     <= 1'b0;
                            pass     <= 1'b0;
                            pass_cnt <= '0;
                            idx      <= '0;
                            rd_idx   <= '0;
                        end
                    end
                    ST_WAIT_CAL: begin
                        if (calib_done) begin
                            state   <= ST_WRITE;
                            wr_data <= DATA_W'(expected(32'd0, pass_cnt));
                        end
                    end
                    ST_WRITE: begin
                        // wr_data is kept one word ahead so it is ready on the next wr_en
                        if (wr_en) begin
                            wr_data <= DATA_W'(expected(32'(idx) + 32'd1, pass_cnt));
                            if (idx == LAST_IDX) begin
                                state      <= ST_SETTLE;
                                idx        <= '0;
                                settle_cnt <= '0;
                            end else begin
                                idx <= idx + 1'b1;
                            end
                        end
                    end
                    ST_SETTLE: begin
                        if (settle_cnt == SETTLE_LAST) begin
                            state         <= ST_READ;
                            rd_mem_enable <= 1'b1;
                            rd_idx        <= '0;
                            tmo_cnt       <= '0;
                        end else begin
                            settle_cnt <= settle_cnt + 1'b1;
                        end
                    end
                    ST_READ: begin
                        if (rd_en) begin
                            tmo_cnt <= '0;
                            rd_idx  <= rd_idx + 1'b1;
                            if (rd_idx == LAST_IDX)
                                state <= ST_DRAIN;
                        end else if (!rd_valid) begin
                            tmo_cnt <= tmo_cnt + 1'b1;
                        end
                    end
                    ST_DRAIN: begin
                        // the checker completes the last compare this cycle
                        rd_mem_enable <= 1'b0;
                        if (more_passes) begin
                            state    <= ST_WRITE;
                            pass_cnt <= pass_cnt + 32'd1;
                            idx      <= '0;
                            wr_data  <= DATA_W'(expected(32'd0, pass_cnt + 32'd1));
                        end else begin
                            state <= ST_DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            pass  <= (fail_next == FAIL_NONE);
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    ddr3_test_checker #(
        .DATA_W (DATA_W),
        .IDX_W  (IDX_W),
        .ERR_W  (ERR_W)
    ) u_checker (
        .clk           (clk),
        .rst_n         (rst_n),
        .clear         (start_ok),
        .flush         (calib_lost | timed_out),
        .rd_en         (rd_en),
        .rd_idx        (rd_idx),
        .pass_cnt      (pass_cnt),
        .rd_data       (rd_data),
        .mismatch      (mismatch),
        .err_cnt       (err_cnt),
        .first_err_idx (first_err_idx)
    );

endmodule

// File: tb/tb_ddr3_selftest_ctrl.sv
// tb/tb_ddr3_selftest_ctrl.sv - self-checking bench for ddr3_selftest_ctrl with a FIFO/DDR3 model
module tb_ddr3_selftest_ctrl;

    localparam int DATA_W      = 16;
    localparam int TEST_LEN    = 1300;
    localparam int SETTLE_CYC  = 64;
    localparam int TIMEOUT_CYC = 100;
    localparam int LOOPS       = 3;
    localparam int ERR_W       = 16;
    localparam int MAX_CYC     = 20000;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              calib_done = 1'b0;
    logic              start = 1'b0;
    logic              wr_full = 1'b0;
    logic              rd_valid = 1'b0;
    logic [DATA_W-1:0] rd_data = '0;
    logic              wr_en, rd_mem_enable, rd_en, busy, done, pass;
    logic [DATA_W-1:0] wr_data;
    logic [1:0]        fail_code;
    logic [ERR_W-1:0]  err_cnt;
    logic [15:0]       first_err_idx;

    ddr3_selftest_ctrl #(
        .DATA_W(DATA_W), .TEST_LEN(TEST_LEN), .SETTLE_CYC(SETTLE_CYC),
        .TIMEOUT_CYC(TIMEOUT_CYC), .LOOPS(LOOPS), .ERR_W(ERR_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .calib_done(calib_done), .start(start),
        .wr_en(wr_en), .wr_data(wr_data), .wr_full(wr_full),
        .rd_mem_enable(rd_mem_enable), .rd_valid(rd_valid), .rd_en(rd_en), .rd_data(rd_data),
        .busy(busy), .done(done), .pass(pass), .fail_code(fail_code),
        .err_cnt(err_cnt), .first_err_idx(first_err_idx)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;

    // Memory/FIFO model and observation state
    logic [DATA_W-1:0] ddr_q[$];
    int                corrupt_n[$];
    logic [DATA_W-1:0] corrupt_m[$];
    logic [DATA_W-1:0] pend_data = '0;
    int cyc = 0;
    int start_cyc = -1, extra_start_cyc = -1, cal_up_cyc = 0;
    int full_mode = 0, gap_pct = 0, rd_limit = 1 << 30, drop_at_read = -1;
    int n_wr, n_rd, bad_wr, wr_while_full, rd_while_empty, wr_while_nocal;
    int settle_seen, settle_bad, last_wr_cyc, last_rd_cyc, done_cyc, drop_cyc;
    bit dropped = 0, finished, prev_rme = 0;
    logic rme_at_done, busy_at_done, done_after_start;
    logic [ERR_W-1:0] err_after_start;

    task automatic step();
        logic [DATA_W-1:0] e, d;
        @(negedge clk);
        cyc++;
        start = (cyc == start_cyc) || (cyc == extra_start_cyc);
        if (!dropped && drop_at_read >= 0 && rd_mem_enable && n_rd >= drop_at_read) begin
            dropped  = 1;
            drop_cyc = cyc;
        end
        calib_done = (cyc >= cal_up_cyc) && !dropped;
        case (full_mode)
            1:       wr_full = ((cyc % 20) < 5);
            2:       wr_full = ($urandom_range(0, 3) == 0);
            default: wr_full = 1'b0;
        endcase
        rd_valid = rd_mem_enable && (ddr_q.size() > 0) && (n_rd < rd_limit) &&
                   ($urandom_range(0, 99) >= gap_pct);
        rd_data = pend_data;
        #1;
        if (wr_en) begin
            if (wr_full) wr_while_full++;
            if (!calib_done) wr_while_nocal++;
            e = DATA_W'((n_wr % TEST_LEN) + (n_wr / TEST_LEN));
            if (wr_data !== e) bad_wr++;
            ddr_q.push_back(wr_data);
            n_wr++;
            last_wr_cyc = cyc;
        end
        if (rd_mem_enable && !prev_rme && n_wr > 0) begin
            settle_seen++;
            if (cyc - last_wr_cyc - 1 != SETTLE_CYC) settle_bad++;
        end
        prev_rme = rd_mem_enable;
        if (rd_en) begin
            if (!rd_valid || ddr_q.size() == 0) begin
                rd_while_empty++;
            end else begin
                d = ddr_q.pop_front();
                foreach (corrupt_n[k]) if (corrupt_n[k] == n_rd) d = d ^ corrupt_m[k];
                pend_data = d;
            end
            n_rd++;
            last_rd_cyc = cyc;
        end
        if (done === 1'b1 && done_cyc < 0) begin
            done_cyc     = cyc;
            rme_at_done  = rd_mem_enable;
            busy_at_done = busy;
        end
    endtask

    task automatic clear_model();
        n_wr = 0; n_rd = 0; bad_wr = 0; wr_while_full = 0; rd_while_empty = 0;
        wr_while_nocal = 0; settle_seen = 0; settle_bad = 0;
        last_wr_cyc = -1; last_rd_cyc = -1; done_cyc = -1; drop_cyc = -1; dropped = 0;
        ddr_q.delete();
    endtask

    // Pulses start, then runs the model until done is seen or the cycle budget expires.
    task automatic run_test(input int cal_off, input int extra_off);
        clear_model();
        start_cyc       = cyc + 1;
        cal_up_cyc      = start_cyc + cal_off;
        extra_start_cyc = (extra_off > 0) ? start_cyc + extra_off : -1;
        step();
        done_cyc = -1;
        step();
        done_after_start = done;
        err_after_start  = err_cnt;
        for (int i = 0; i < MAX_CYC && done_cyc < 0; i++) step();
        finished = (done_cyc >= 0);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        n_cmp++;
        if ({wr_en, rd_en, rd_mem_enable, busy, done, pass, fail_code} !== 9'd0) begin
            n_fail++;
            $display("FAIL reset_flags: got %b want 0", {wr_en, rd_en, rd_mem_enable, busy, done, pass, fail_code});
        end
        n_cmp++;
        if ({wr_data, err_cnt, first_err_idx} !== '0) begin
            n_fail++;
            $display("FAIL reset_values: got wr_data=%0d err_cnt=%0d first=%0d want 0", wr_data, err_cnt, first_err_idx);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) step();
        n_cmp++;
        if ({busy, done, wr_en} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_idle: got busy=%b done=%b wr_en=%b want 0", busy, done, wr_en);
        end
    endtask

    task automatic test_ideal_loops();
        full_mode = 0; gap_pct = 25; rd_limit = 1 << 30; drop_at_read = -1;
        corrupt_n.delete(); corrupt_m.delete();
        run_test($urandom_range(3, 40), $urandom_range(200, 3000));
        n_cmp++; if (finished !== 1'b1) begin n_fail++; $display("FAIL ideal_done: got %0d want 1", finished); end
        n_cmp++; if (n_wr !== LOOPS * TEST_LEN) begin n_fail++; $display("FAIL ideal_writes: got %0d want %0d", n_wr, LOOPS * TEST_LEN); end
        n_cmp++; if (n_rd !== LOOPS * TEST_LEN) begin n_fail++; $display("FAIL ideal_reads: got %0d want %0d", n_rd, LOOPS * TEST_LEN); end
        n_cmp++; if (bad_wr !== 0) begin n_fail++; $display("FAIL ideal_wr_data: got %0d bad words want 0", bad_wr); end
        n_cmp++; if (wr_while_nocal !== 0) begin n_fail++; $display("FAIL ideal_wait_cal: got %0d writes before calib want 0", wr_while_nocal); end
        n_cmp++; if (rd_while_empty !== 0) begin n_fail++; $display("FAIL ideal_rd_empty: got %0d want 0", rd_while_empty); end
        n_cmp++; if (settle_seen !== LOOPS || settle_bad !== 0) begin n_fail++; $display("FAIL ideal_settle: got %0d rises %0d bad want %0d rises 0 bad", settle_seen, settle_bad, LOOPS); end
        n_cmp++; if ({pass, fail_code, busy_at_done} !== 4'b1000) begin n_fail++; $display("FAIL ideal_status: got pass=%b fail=%0d busy=%b want 1 0 0", pass, fail_code, busy_at_done); end
        n_cmp++; if (err_cnt !== 0 || first_err_idx !== 0) begin n_fail++; $display("FAIL ideal_errs: got %0d/%0d want 0/0", err_cnt, first_err_idx); end
        repeat (5) step();
        n_cmp++; if ({done, pass, rd_mem_enable} !== 3'b110) begin n_fail++; $display("FAIL ideal_hold: got done=%b pass=%b rme=%b want 1 1 0", done, pass, rd_mem_enable); end
    endtask

    task automatic test_corrupt();
        int r;
        full_mode = 2; gap_pct = 10; rd_limit = 1 << 30; drop_at_read = -1;
        r = $urandom_range(0, TEST_LEN - 1);
        corrupt_n.delete(); corrupt_m.delete();
        corrupt_n.push_back(37);               corrupt_m.push_back(16'h0001);
        corrupt_n.push_back(900);              corrupt_m.push_back(DATA_W'($urandom_range(1, 65535)));
        corrupt_n.push_back(2 * TEST_LEN + r); corrupt_m.push_back(DATA_W'($urandom_range(1, 65535)));
        run_test(0, 0);
        n_cmp++; if (finished !== 1'b1) begin n_fail++; $display("FAIL corrupt_done: got %0d want 1", finished); end
        n_cmp++; if (err_cnt !== 3) begin n_fail++; $display("FAIL corrupt_err_cnt: got %0d want 3", err_cnt); end
        n_cmp++; if (first_err_idx !== 37) begin n_fail++; $display("FAIL corrupt_first_idx: got %0d want 37", first_err_idx); end
        n_cmp++; if ({pass, fail_code} !== 3'b001) begin n_fail++; $display("FAIL corrupt_status: got pass=%b fail=%0d want 0 1", pass, fail_code); end
        n_cmp++; if (n_rd !== LOOPS * TEST_LEN) begin n_fail++; $display("FAIL corrupt_reads: got %0d want %0d", n_rd, LOOPS * TEST_LEN); end
        corrupt_n.delete(); corrupt_m.delete();
    endtask

    task automatic test_wr_full_back_to_back();
        full_mode = 1; gap_pct = 0; rd_limit = 1 << 30; drop_at_read = -1;
        run_test(0, 0);
        n_cmp++; if ({done_after_start, err_after_start} !== '0) begin n_fail++; $display("FAIL b2b_clear: got done=%b err=%0d want 0 0", done_after_start, err_after_start); end
        n_cmp++; if (finished !== 1'b1) begin n_fail++; $display("FAIL wrfull_done: got %0d want 1", finished); end
        n_cmp++; if (wr_while_full !== 0) begin n_fail++; $display("FAIL wrfull_no_write: got %0d want 0", wr_while_full); end
        n_cmp++; if (bad_wr !== 0 || n_wr !== LOOPS * TEST_LEN) begin n_fail++; $display("FAIL wrfull_sequence: got %0d bad of %0d want 0 of %0d", bad_wr, n_wr, LOOPS * TEST_LEN); end
        n_cmp++; if ({pass, fail_code} !== 3'b100) begin n_fail++; $display("FAIL wrfull_status: got pass=%b fail=%0d want 1 0", pass, fail_code); end
    endtask

    task automatic test_timeout();
        full_mode = 0; gap_pct = 20; rd_limit = 500; drop_at_read = -1;
        run_test(0, 0);
        n_cmp++; if (finished !== 1'b1) begin n_fail++; $display("FAIL timeout_done: got %0d want 1", finished); end
        n_cmp++; if (n_rd !== 500) begin n_fail++; $display("FAIL timeout_reads: got %0d want 500", n_rd); end
        n_cmp++; if (done_cyc - last_rd_cyc !== TIMEOUT_CYC + 1) begin n_fail++; $display("FAIL timeout_latency: got %0d want %0d", done_cyc - last_rd_cyc, TIMEOUT_CYC + 1); end
        n_cmp++; if ({pass, fail_code} !== 3'b010) begin n_fail++; $display("FAIL timeout_status: got pass=%b fail=%0d want 0 2", pass, fail_code); end
        n_cmp++; if (err_cnt !== 0) begin n_fail++; $display("FAIL timeout_errs: got %0d want 0", err_cnt); end
        rd_limit = 1 << 30;
    endtask

    task automatic test_calib_lost();
        full_mode = 0; gap_pct = 15; rd_limit = 1 << 30;
        drop_at_read = $urandom_range(100, 1200);
        run_test(0, 0);
        n_cmp++; if (finished !== 1'b1) begin n_fail++; $display("FAIL calib_done_seen: got %0d want 1", finished); end
        n_cmp++; if (done_cyc - drop_cyc !== 1) begin n_fail++; $display("FAIL calib_latency: got %0d want 1", done_cyc - drop_cyc); end
        n_cmp++; if ({pass, fail_code, rme_at_done, busy_at_done} !== 5'b01100) begin n_fail++; $display("FAIL calib_status: got pass=%b fail=%0d rme=%b busy=%b want 0 3 0 0", pass, fail_code, rme_at_done, busy_at_done); end
        n_cmp++; if (n_wr !== TEST_LEN) begin n_fail++; $display("FAIL calib_writes: got %0d want %0d", n_wr, TEST_LEN); end
        drop_at_read = -1;
    endtask

    task automatic test_reset_mid_write();
        int target;
        full_mode = 2; gap_pct = 0; drop_at_read = -1;
        target = $urandom_range(10, 500);
        clear_model();
        start_cyc = cyc + 1; cal_up_cyc = 0; extra_start_cyc = -1;
        for (int i = 0; i < MAX_CYC && n_wr < target; i++) step();
        n_cmp++; if (n_wr < target) begin n_fail++; $display("FAIL rstmid_reach: got %0d writes want %0d", n_wr, target); end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({wr_en, rd_en, rd_mem_enable, busy, done, pass, fail_code} !== 9'd0 ||
            {wr_data, err_cnt, first_err_idx} !== '0) begin
            n_fail++;
            $display("FAIL rstmid_outputs: got wr_en=%b busy=%b wr_data=%0d err=%0d want all 0", wr_en, busy, wr_data, err_cnt);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        full_mode = 0;
        repeat (3) step();
        n_cmp++; if ({busy, done, wr_en} !== 3'b000) begin n_fail++; $display("FAIL rstmid_idle: got busy=%b done=%b wr_en=%b want 0", busy, done, wr_en); end
    endtask

    initial begin
        test_reset();
        test_ideal_loops();
        test_corrupt();
        test_wr_full_back_to_back();
        test_timeout();
        test_calib_lost();
        test_reset_mid_write();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
